// File: rtl/game_pkg.sv
// Shared definitions for the game input path: press FSM encoding, debounce
// default and answer width.
package game_pkg;

    localparam int ANSWER_W         = 12;
    localparam int CNT_W            = 20;
    localparam int DEBOUNCE_DEFAULT = 1_000_000;  // 20 ms at 50 MHz

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } press_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; RST_VAL is the
// inactive level the chain holds while in reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/answer_latch.sv
// Debounced answer-submit button: one go_pulse per accepted press, snapshots
// the answer switches while a round is running, and flags the timer expiring.
module answer_latch
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                key_n,
    input  logic [ANSWER_W-1:0] sw,
    input  logic                enable,
    input  logic                time_up,
    output logic                go_pulse,
    output logic [ANSWER_W-1:0] answer,
    output logic                answer_valid,
    output logic                timeout,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    press_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             key_sync;
    logic             key_s;
    logic             cnt_done;
    logic             accept;
    logic             tu_q;
    logic             tu_rise;

    sync_2ff #(.RST_VAL(1'b1)) u_key_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (key_n),
        .q      (key_sync)
    );

    assign key_s    = ~key_sync;
    assign cnt_done = (cnt == CNT_LAST);
    // Saturate rather than wrap so a stuck state can never alias a short count.
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign accept   = (state == PRESS_DB) && key_s && cnt_done;
    assign tu_rise  = time_up && !tu_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            tu_q         <= 1'b0;
            answer       <= '0;
            go_pulse     <= 1'b0;
            answer_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            go_pulse     <= 1'b0;
            answer_valid <= 1'b0;
            tu_q         <= time_up;
            // An accepted press on the same edge swallows the timer expiry.
            timeout      <= tu_rise && enable && !accept;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (key_s) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    busy <= 1'b1;
                    if (!key_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt_done) begin
                        state    <= HELD;
                        cnt      <= '0;
                        go_pulse <= 1'b1;
                        if (enable) begin
                            answer       <= sw;
                            answer_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    busy <= 1'b1;
                    if (!key_s) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end
                end
                RELEASE_DB: begin
                    busy <= 1'b1;
                    if (key_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_answer_latch.sv
// Directed bench for answer_latch with a short debounce window.
module tb_answer_latch;

    localparam int D = 4;

    logic        clk;
    logic        resetn;
    logic        key_n;
    logic [11:0] sw;
    logic        enable;
    logic        time_up;
    logic        go_pulse;
    logic [11:0] answer;
    logic        answer_valid;
    logic        timeout;
    logic        busy;

    int nchk  = 0;
    int npass = 0;

    answer_latch #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .key_n        (key_n),
        .sw           (sw),
        .enable       (enable),
        .time_up      (time_up),
        .go_pulse     (go_pulse),
        .answer       (answer),
        .answer_valid (answer_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got == exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, tallying output activity seen after each edge.
    task automatic run(input int n, output int gos, output int first_go,
                       output int avs, output int tos, output int bsy);
        gos = 0; first_go = -1; avs = 0; tos = 0; bsy = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (go_pulse) begin
                gos++;
                if (first_go < 0) first_go = i;
            end
            if (answer_valid) avs++;
            if (timeout) tos++;
            if (busy) bsy++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, f, a, t, b;
        resetn = 1'b0; key_n = 1'b1; sw = '0; enable = 1'b0; time_up = 1'b0;
        #3;
        chk("rst_go", go_pulse, 0);
        chk("rst_answer", answer, 0);
        chk("rst_av", answer_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // Press while no round running: pulse but no capture.
        enable = 1'b0; sw = 12'h111; key_n = 1'b0;
        tick();
        run(20, g, f, a, t, b);
        chk("dis_gos", g, 1);
        chk("dis_lat", f, 6);
        chk("dis_av", a, 0);
        chk("dis_answer", answer, 12'h000);
        key_n = 1'b1;
        run(20, g, f, a, t, b);
        chk("dis_rel_gos", g, 0);
        chk("dis_rel_busy", busy, 0);

        // Normal press, long hold.
        enable = 1'b1; sw = 12'h027; key_n = 1'b0;
        tick();
        run(6, g, f, a, t, b);
        chk("prs_lat", f, 6);
        chk("prs_gos", g, 1);
        chk("prs_go_now", go_pulse, 1);
        chk("prs_av_now", answer_valid, 1);
        tick();
        chk("prs_answer", answer, 12'h027);
        chk("prs_go_drop", go_pulse, 0);
        sw = 12'h0ff;
        run(100, g, f, a, t, b);
        chk("hold_gos", g, 0);
        chk("hold_av", a, 0);
        chk("hold_answer", answer, 12'h027);
        chk("hold_busy", busy, 1);

        // Release with a bounce back to pressed while in RELEASE_DB.
        key_n = 1'b1;
        run(3, g, f, a, t, b);
        key_n = 1'b0;
        run(2, g, f, a, t, b);
        key_n = 1'b1;
        run(3, g, f, a, t, b);
        chk("bnc_busy", b, 3);
        key_n = 1'b0;
        run(2, g, f, a, t, b);
        key_n = 1'b1;
        run(20, g, f, a, t, b);
        chk("bnc_gos", g, 0);
        chk("bnc_busy_end", busy, 0);

        // Two-cycle glitch is rejected.
        key_n = 1'b0;
        tick(); tick();
        key_n = 1'b1;
        run(10, g, f, a, t, b);
        chk("gl_gos", g, 0);
        chk("gl_busy_seen", (b > 0) ? 1 : 0, 1);
        chk("gl_busy_end", busy, 0);
        chk("gl_answer", answer, 12'h027);

        // Timer expiry on the accept edge: press wins.
        sw = 12'h3a5; key_n = 1'b0;
        tick();
        run(5, g, f, a, t, b);
        chk("sim_pre_gos", g, 0);
        time_up = 1'b1;
        run(1, g, f, a, t, b);
        chk("sim_gos", g, 1);
        chk("sim_av", a, 1);
        chk("sim_to_now", timeout, 0);
        run(10, g, f, a, t, b);
        chk("sim_to_after", t, 0);
        chk("sim_answer", answer, 12'h3a5);
        key_n = 1'b1; time_up = 1'b0;
        run(20, g, f, a, t, b);

        // Level time_up held: exactly one timeout.
        time_up = 1'b1;
        run(50, g, f, a, t, b);
        chk("to_count", t, 1);
        time_up = 1'b0;
        enable = 1'b0;
        tick();
        time_up = 1'b1;
        run(10, g, f, a, t, b);
        chk("to_dis_count", t, 0);
        time_up = 1'b0; enable = 1'b1;
        tick();

        // Reset while held discards the press; re-debounce after release.
        sw = 12'h5a5; key_n = 1'b0;
        tick();
        run(10, g, f, a, t, b);
        chk("rh_gos", g, 1);
        resetn = 1'b0;
        #1;
        chk("rh_answer", answer, 0);
        chk("rh_busy", busy, 0);
        chk("rh_go", go_pulse, 0);
        chk("rh_av", answer_valid, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        run(20, g, f, a, t, b);
        chk("rh2_gos", g, 1);
        chk("rh2_lat", f, 6);
        chk("rh2_answer", answer, 12'h5a5);
        key_n = 1'b1;
        run(20, g, f, a, t, b);
        chk("rh2_rel_busy", busy, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
